// File: rtl/elevator_pkg.sv
// Shared encodings for the LOOK elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elevator_look_dir.sv
// Combinational look-ahead: are there latched calls above / below the current floor.
module elevator_look_dir #(
  parameter  int unsigned N_FLOORS = 8,
  localparam int unsigned FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  floor,
  output logic                ahead_up_c,
  output logic                ahead_dn_c
);

  always_comb begin
    ahead_up_c = 1'b0;
    ahead_dn_c = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (i > 32'(floor)) ahead_up_c = ahead_up_c | pending[i];
      if (i < 32'(floor)) ahead_dn_c = ahead_dn_c | pending[i];
    end
  end

endmodule

// File: rtl/elevator_look_controller.sv
// N-floor elevator car controller with LOOK scheduling, travel timing and door dwell.
// Optional DOOR_HOLD_EN adds a door_hold input that freezes the dwell countdown.
module elevator_look_controller
  import elevator_pkg::*;
#(
  parameter  int unsigned N_FLOORS      = 8,
  parameter  int unsigned TRAVEL_CYCLES = 4,
  parameter  int unsigned DOOR_CYCLES   = 10,
  localparam int unsigned FLOOR_W       = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req,
`ifdef DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  output logic [FLOOR_W-1:0]  floor,
  output logic                moving,
  output logic                door,
  output logic                direction,
  output logic [N_FLOORS-1:0] pending,
  output logic                arrive
);

  localparam int unsigned TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DOOR_W   = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);

  state_t              state;
  logic [TRAVEL_W-1:0] travel_cnt;
  logic [DOOR_W-1:0]   door_cnt;

  logic                ahead_up_c;
  logic                ahead_dn_c;
  logic                ahead_dir_c;
  logic                go_up_c;
  logic                go_dn_c;
  logic                hold_c;
  logic [FLOOR_W-1:0]  step_floor_c;
  logic [N_FLOORS-1:0] floor_oh_c;
  logic [N_FLOORS-1:0] step_oh_c;
  logic [N_FLOORS-1:0] latched_c;

  elevator_look_dir #(
    .N_FLOORS (N_FLOORS)
  ) u_dir (
    .pending    (pending),
    .floor      (floor),
    .ahead_up_c (ahead_up_c),
    .ahead_dn_c (ahead_dn_c)
  );

`ifdef DOOR_HOLD_EN
  assign hold_c = door_hold;
`else
  assign hold_c = 1'b0;
`endif

  // Request latch input and sweep decisions from registered state.
  always_comb begin
    floor_oh_c = '0;
    floor_oh_c[floor] = 1'b1;
    step_floor_c = (direction == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    step_oh_c = '0;
    step_oh_c[step_floor_c] = 1'b1;
    // A call for the floor whose door is open only restarts the dwell.
    latched_c = pending | ((state == DOOR) ? (req & ~floor_oh_c) : req);
    ahead_dir_c = (direction == DIR_UP) ? ahead_up_c : ahead_dn_c;
    go_up_c = ahead_up_c & ((direction == DIR_UP) | ~ahead_dn_c);
    go_dn_c = ahead_dn_c & ((direction == DIR_DN) | ~ahead_up_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      floor      <= '0;
      moving     <= 1'b0;
      door       <= 1'b0;
      direction  <= DIR_UP;
      pending    <= '0;
      arrive     <= 1'b0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      arrive  <= 1'b0;
      pending <= latched_c;
      case (state)
        IDLE: begin
          if (pending[floor]) begin
            state    <= DOOR;
            door     <= 1'b1;
            door_cnt <= DOOR_LOAD;
            pending  <= latched_c & ~floor_oh_c;
          end else if (go_up_c || go_dn_c) begin
            state      <= MOVE;
            moving     <= 1'b1;
            direction  <= go_up_c ? DIR_UP : DIR_DN;
            travel_cnt <= TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (travel_cnt != '0) begin
            travel_cnt <= travel_cnt - TRAVEL_W'(1);
          end else if (!ahead_dir_c) begin
            // Nothing ahead: never step past a terminal floor.
            state  <= IDLE;
            moving <= 1'b0;
          end else begin
            floor      <= step_floor_c;
            arrive     <= 1'b1;
            travel_cnt <= TRAVEL_LOAD;
            // Without a stop here, a call ahead of the old floor lies beyond the new one.
            if (pending[step_floor_c]) begin
              state    <= DOOR;
              moving   <= 1'b0;
              door     <= 1'b1;
              door_cnt <= DOOR_LOAD;
              pending  <= latched_c & ~step_oh_c;
            end
          end
        end
        DOOR: begin
          if (req[floor]) begin
            door_cnt <= DOOR_LOAD;
          end else if (!hold_c) begin
            if (door_cnt == '0) begin
              state <= IDLE;
              door  <= 1'b0;
            end else begin
              door_cnt <= door_cnt - DOOR_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
          door   <= 1'b0;
        end
      endcase
    end
  end

endmodule
